// File: rtl/fmas_seq.sv
// fmas_seq: issue/collect sequencer wrapped around the fixed-latency fmas FMA datapath.
//
// It accepts operand triples over a valid/ready handshake and applies the sign
// transforms for FMADD/FMSUB/FNMSUB/FNMADD before they reach fmas. A tagged valid
// shift register tracks each operation through the fmas latency. Results and flags are
// captured into a first-word-fall-through FIFO. Credits keep that FIFO from overflowing,
// because fmas itself cannot stall. Popped flags are ORed into a sticky exception register.
//
// Ports:
//   clk, reset               clock; asynchronous active-low reset
//   in_valid/in_ready        operation handshake; in_op, in_tag, in_x/y/z carry the operation
//   fma_req, fma_x/y/z       request to fmas (combinational from the inputs)
//   fma_rslt, fma_flag       fmas result, valid LAT cycles after the request
//   out_valid/out_ready      result handshake; out_rslt, out_flag, out_tag carry the result
//   fflags, fflags_clr       sticky OR of popped flags, and its clear
//   busy                     any operation in flight or waiting in the FIFO
module fmas_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned LAT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [31:0]      in_z,
  output logic             fma_req,
  output logic [31:0]      fma_x,
  output logic [31:0]      fma_y,
  output logic [31:0]      fma_z,
  input  logic [31:0]      fma_rslt,
  input  logic [4:0]       fma_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rslt,
  output logic [4:0]       out_flag,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output logic             busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic             issue, pop, wr_en;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]       fflags_q, fflags_d;

  logic             pipe_vld_q [LAT];
  logic [TAG_W-1:0] pipe_tag_q [LAT];

  logic [31:0]      rslt_mem [DEPTH];
  logic [4:0]       flag_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];

  // ---------------------------------------------------------------------------
  // Issue side
  // ---------------------------------------------------------------------------
  // Ready is held low while reset is asserted, even though the credit count reads 0.
  assign in_ready = reset & (cnt_q < CNT_MAX);
  assign issue    = in_valid & in_ready;
  assign fma_req  = issue;

  // The sign flips are raw bit inversions, so NaN/Inf/zero operands are flipped too.
  assign fma_x = in_x;
  assign fma_y = {in_y[31] ^ in_op[1], in_y[30:0]};
  assign fma_z = {in_z[31] ^ (in_op == 2'b01 || in_op == 2'b10), in_z[30:0]};

  // ---------------------------------------------------------------------------
  // Credits: FIFO occupancy plus operations in flight
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    unique case ({issue, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  assign busy = (cnt_q != '0);

  // ---------------------------------------------------------------------------
  // Tracking pipeline: advances every cycle, because fmas cannot stall
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(LAT); i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_tag_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= issue;
      pipe_tag_q[0] <= in_tag;
      for (int i = 1; i < int'(LAT); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  // The last pipeline stage lines up with the cycle in which fma_rslt and fma_flag are valid.
  assign wr_en = pipe_vld_q[LAT-1];

  // ---------------------------------------------------------------------------
  // Result FIFO (first-word-fall-through, no write-to-read bypass)
  // ---------------------------------------------------------------------------
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_rslt  = rslt_mem[rd_ptr_q];
  assign out_flag  = flag_mem[rd_ptr_q];
  assign out_tag   = tag_mem[rd_ptr_q];

  always_comb begin
    occ_d = occ_q;
    unique case ({wr_en, pop})
      2'b10:   occ_d = occ_q + CNT_ONE;
      2'b01:   occ_d = occ_q - CNT_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Storage needs no reset; it is only observable while out_valid is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rslt_mem[wr_ptr_q] <= fma_rslt;
      // DZ cannot occur in an FMA, so bit 3 is forced low.
      flag_mem[wr_ptr_q] <= fma_flag & 5'b10111;
      tag_mem[wr_ptr_q]  <= pipe_tag_q[LAT-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags
  // ---------------------------------------------------------------------------
  always_comb begin
    fflags_d = fflags_q;
    if (pop) begin
      fflags_d = (fflags_clr ? 5'b00000 : fflags_q) | out_flag;
    end else if (fflags_clr) begin
      fflags_d = 5'b00000;
    end
  end

  assign fflags = fflags_q;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fflags_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      fflags_q <= fflags_d;
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_fmas_seq.sv
module tb_fmas_seq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned LAT   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      in_x, in_y, in_z;
  logic             fma_req;
  logic [31:0]      fma_x, fma_y, fma_z;
  logic [31:0]      fma_rslt;
  logic [4:0]       fma_flag;
  logic             out_valid, out_ready;
  logic [31:0]      out_rslt;
  logic [4:0]       out_flag;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       fflags;
  logic             fflags_clr;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard entries: {tag, flag, rslt}
  logic [40:0] exp_q[$];

  fmas_seq #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W),
    .LAT  (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .fma_req   (fma_req),
    .fma_x     (fma_x),
    .fma_y     (fma_y),
    .fma_z     (fma_z),
    .fma_rslt  (fma_rslt),
    .fma_flag  (fma_flag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rslt  (out_rslt),
    .out_flag  (out_flag),
    .out_tag   (out_tag),
    .fflags    (fflags),
    .fflags_clr(fflags_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // x*y+z for the operand triples used here; returns {flag, rslt}.
  function automatic logic [36:0] fma_lut(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
    logic [95:0] k;
    k = {x, y, z};
    case (k)
      {32'h3F800000, 32'h40000000, 32'h40400000}: return {5'h00, 32'h40A00000}; //  2+3
      {32'h3F800000, 32'h40000000, 32'hC0400000}: return {5'h00, 32'hBF800000}; //  2-3
      {32'h3F800000, 32'hC0000000, 32'hC0400000}: return {5'h00, 32'hC0A00000}; // -2-3
      {32'h3F800000, 32'hC0000000, 32'h40400000}: return {5'h00, 32'h3F800000}; // -2+3
      {32'h7F800000, 32'h00000000, 32'h3F800000}: return {5'h10, 32'hFFC00000}; // inf*0
      {32'h7F7FFFFF, 32'h40000000, 32'h00000000}: return {5'h05, 32'h7F800000}; // overflow
      {32'h3F800001, 32'h3F800001, 32'h00000000}: return {5'h01, 32'h3F800002}; // inexact
      default:                                    return {5'h00, 32'hDEADBEEF};
    endcase
  endfunction

  // Behavioural fmas: fixed two-cycle latency, no stall.
  logic [36:0] m1, m2;
  always @(posedge clk) begin
    m1 <= fma_req ? fma_lut(fma_x, fma_y, fma_z) : 37'h0;
    m2 <= m1;
  end
  assign fma_rslt = m2[31:0];
  assign fma_flag = m2[36:32];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: compare pops against the scoreboard, then push newly issued operations.
  initial begin
    logic [40:0] e;
    logic [31:0] ty, tz;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", {32'h0, out_rslt}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_rslt", {32'h0, out_rslt}, {32'h0, e[31:0]});
          check_eq("out_flag", {59'h0, out_flag}, {59'h0, e[36:32]});
          check_eq("out_tag", {60'h0, out_tag}, {60'h0, e[40:37]});
        end
      end
      if (reset && in_valid && in_ready) begin
        ty = {in_y[31] ^ in_op[1], in_y[30:0]};
        tz = {in_z[31] ^ (in_op == 2'b01 || in_op == 2'b10), in_z[30:0]};
        exp_q.push_back({in_tag, fma_lut(in_x, ty, tz)});
        check_eq("credit_bound", {63'h0, exp_q.size() <= DEPTH}, 64'h1);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation and hold it until accepted (bounded).
  task automatic issue(input logic [1:0] op, input logic [3:0] tag, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] z);
    in_valid = 1'b1;
    in_op    = op;
    in_tag   = tag;
    in_x     = x;
    in_y     = y;
    in_z     = z;
    for (int n = 0; n < 40 && !in_ready; n++) next_cyc();
    if (!in_ready) check_eq("issue_timeout", 64'h0, 64'h1);
    else next_cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      next_cyc();
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'h0);
    next_cyc();
    check_eq("idle_busy", {63'h0, busy}, 64'h0);
  endtask

  initial begin
    int k;
    logic acc;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_op      = 2'b00;
    in_tag     = '0;
    in_x       = '0;
    in_y       = '0;
    in_z       = '0;
    out_ready  = 1'b1;
    fflags_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", {63'h0, in_ready}, 64'h0);
    check_eq("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check_eq("rst_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_fflags", {59'h0, fflags}, 64'h0);
    check_eq("rst_fma_req", {63'h0, fma_req}, 64'h0);
    reset = 1'b1;
    next_cyc();
    check_eq("post_rst_in_ready", {63'h0, in_ready}, 64'h1);

    // Single fmadd: result visible exactly three cycles after issue
    issue(2'b00, 4'h1, 32'h3F800000, 32'h40000000, 32'h40400000);
    @(negedge clk); check_eq("lat_t1", {63'h0, out_valid}, 64'h0);
    @(negedge clk); check_eq("lat_t2", {63'h0, out_valid}, 64'h0);
    @(negedge clk); check_eq("lat_t3", {63'h0, out_valid}, 64'h1);
    next_cyc();
    drain();

    // Back-to-back op 01 then op 10: consecutive results, in order
    issue(2'b01, 4'h2, 32'h3F800000, 32'h40000000, 32'h40400000);
    issue(2'b10, 4'h3, 32'h3F800000, 32'h40000000, 32'h40400000);
    @(negedge clk); check_eq("b2b_t2", {63'h0, out_valid}, 64'h0);
    @(negedge clk); check_eq("b2b_t3", {63'h0, out_valid}, 64'h1);
    @(negedge clk); check_eq("b2b_t4", {63'h0, out_valid}, 64'h1);
    @(negedge clk); check_eq("b2b_t5", {63'h0, out_valid}, 64'h0);
    next_cyc();
    drain();

    // Backpressure: offer 6 with out_ready low; only DEPTH are accepted
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_op    = 2'(k % 4);
      in_tag   = 4'(8 + k);
      in_x     = 32'h3F800000;
      in_y     = 32'h40000000;
      in_z     = 32'h40400000;
      check_eq("bp_ready", {63'h0, in_ready}, {63'h0, c < 4});
      acc = in_ready;
      next_cyc();
      if (acc) k++;
    end
    check_eq("bp_accepted", 64'(k), 64'd4);
    check_eq("bp_full_valid", {63'h0, out_valid}, 64'h1);
    out_ready = 1'b1;
    check_eq("bp_ready_at_pop", {63'h0, in_ready}, 64'h0);
    next_cyc();
    check_eq("bp_ready_after_pop", {63'h0, in_ready}, 64'h1);
    for (int c = 0; c < 20 && k < 6; c++) begin
      in_op  = 2'(k % 4);
      in_tag = 4'(8 + k);
      acc    = in_ready;
      next_cyc();
      if (acc) k++;
    end
    in_valid = 1'b0;
    check_eq("bp_all_accepted", 64'(k), 64'd6);
    drain();

    // Exception flags
    issue(2'b00, 4'h4, 32'h7F800000, 32'h00000000, 32'h3F800000);
    drain();
    check_eq("fflags_nv", {59'h0, fflags}, 64'h10);
    issue(2'b00, 4'h5, 32'h7F7FFFFF, 32'h40000000, 32'h00000000);
    drain();
    check_eq("fflags_nv_of", {59'h0, fflags}, 64'h15);
    issue(2'b00, 4'h6, 32'h3F800001, 32'h3F800001, 32'h00000000);
    next_cyc();
    next_cyc();
    check_eq("clr_pop_valid", {63'h0, out_valid}, 64'h1);
    fflags_clr = 1'b1;
    next_cyc();
    fflags_clr = 1'b0;
    check_eq("fflags_clr_pop", {59'h0, fflags}, 64'h01);
    fflags_clr = 1'b1;
    next_cyc();
    fflags_clr = 1'b0;
    check_eq("fflags_clr_only", {59'h0, fflags}, 64'h00);
    drain();

    // Reset with two operations in flight and two waiting in the FIFO
    issue(2'b00, 4'h7, 32'h7F800000, 32'h00000000, 32'h3F800000);
    drain();
    check_eq("pre_rst_fflags", {59'h0, fflags}, 64'h10);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(2'(i), 4'(i), 32'h3F800000, 32'h40000000, 32'h40400000);
    check_eq("pre_rst_busy", {63'h0, busy}, 64'h1);
    check_eq("pre_rst_valid", {63'h0, out_valid}, 64'h1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_valid", {63'h0, out_valid}, 64'h0);
    check_eq("mid_rst_busy", {63'h0, busy}, 64'h0);
    check_eq("mid_rst_fflags", {59'h0, fflags}, 64'h0);
    check_eq("mid_rst_ready", {63'h0, in_ready}, 64'h0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("no_stale", {63'h0, out_valid}, 64'h0);
    end
    next_cyc();
    issue(2'b00, 4'h9, 32'h3F800000, 32'h40000000, 32'h40400000);
    @(negedge clk); check_eq("rst_lat_t1", {63'h0, out_valid}, 64'h0);
    @(negedge clk); check_eq("rst_lat_t2", {63'h0, out_valid}, 64'h0);
    @(negedge clk); check_eq("rst_lat_t3", {63'h0, out_valid}, 64'h1);
    next_cyc();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
